soc_wb_arbiter: RTL and testbench

Two-master, one-slave Wishbone (classic, B4) arbiter that shares the SoC's internal peripheral bus between the Caravel management host (master 0) and the on-chip core data port (master 1). It sits inside `soc`, between the Caravel Wishbone slave port and the peripheral interconnect. It provides round-robin fairness, bus locking for the duration of `cyc`, and a watchdog that terminates stalled transfers with an error.

---
 rtl/soc_wb_pkg.sv | 30 +++
 rtl/soc_wb_arbiter_if.sv | 48 ++++
 rtl/soc_wb_watchdog.sv | 29 ++
 rtl/soc_wb_arbiter.sv | 108 ++++++++++
 tb/tb_soc_wb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_wb_pkg.sv
// Shared types for the SoC peripheral-bus arbiter: Wishbone request/response
// records and the ownership state encoding.
package soc_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic                 ack;
        logic                 err;
        logic [WB_DATA_W-1:0] dat;
    } wb_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } wb_arb_state_e;

endpackage

// File: rtl/soc_wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface soc_wb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic              m0_ack_o, m0_err_o;
    logic [DATA_W-1:0] m0_dat_o;

    logic              m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [DATA_W-1:0] m1_dat_i;
    logic              m1_ack_o, m1_err_o;
    logic [DATA_W-1:0] m1_dat_o;

    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [SEL_W-1:0]  s_sel_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [DATA_W-1:0] s_dat_o;
    logic              s_ack_i;
    logic [DATA_W-1:0] s_dat_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  s_ack_i, s_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output s_ack_i, s_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

endinterface

// File: rtl/soc_wb_watchdog.sv
// Stall counter for the owned transfer: flags expiry when a strobe has gone
// unacknowledged for TIMEOUT cycles. TIMEOUT = 0 disables expiry.
module soc_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    assign expire = (TIMEOUT != 0) && en && (cnt_q == LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr || expire) begin
            cnt_q <= '0;
        end else if (en && (TIMEOUT != 0)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/soc_wb_arbiter.sv
// Two-master Wishbone B4 arbiter: round-robin grant, bus lock for the whole of
// cyc, and watchdog error termination of stalled strobes.
module soc_wb_arbiter
    import soc_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    soc_wb_arbiter_if.slave bus,
    output logic            timeout_irq_o
);
    wb_arb_state_e state_q, state_d;
    logic          ptr_q, ptr_d;
    wb_req_t       req0, req1, own_req;
    wb_rsp_t       rsp0, rsp1;
    logic          m0_req, m1_req, stall, expire;

    always_comb begin
        req0 = '{cyc: bus.m0_cyc_i, stb: bus.m0_stb_i, we: bus.m0_we_i,
                 sel: bus.m0_sel_i, adr: bus.m0_adr_i, dat: bus.m0_dat_i};
        req1 = '{cyc: bus.m1_cyc_i, stb: bus.m1_stb_i, we: bus.m1_we_i,
                 sel: bus.m1_sel_i, adr: bus.m1_adr_i, dat: bus.m1_dat_i};
    end

    assign m0_req = req0.cyc & req0.stb;
    assign m1_req = req1.cyc & req1.stb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The pointer names the preferred master on a tie and flips on every release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || !ptr_q)) state_d = OWN0;
                else if (m1_req)                   state_d = OWN1;
            end
            OWN0: begin
                if (!req0.cyc) begin
                    state_d = IDLE;
                    ptr_d   = 1'b1;
                end
            end
            OWN1: begin
                if (!req1.cyc) begin
                    state_d = IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        own_req = '0;
        unique case (state_q)
            OWN0:    own_req = req0;
            OWN1:    own_req = req1;
            default: own_req = '0;
        endcase
    end

    // An ack in the expiry cycle keeps the stall term low, so the ack wins.
    assign stall = own_req.stb & ~bus.s_ack_i;

    soc_wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (stall),
        .clr    (~stall),
        .expire (expire)
    );

    assign bus.s_cyc_o = own_req.cyc;
    assign bus.s_stb_o = own_req.stb & ~expire;
    assign bus.s_we_o  = own_req.we;
    assign bus.s_sel_o = own_req.sel;
    assign bus.s_adr_o = own_req.adr;
    assign bus.s_dat_o = own_req.dat;

    always_comb begin
        rsp0 = '{ack: (state_q == OWN0) & bus.s_ack_i,
                 err: (state_q == OWN0) & expire, dat: bus.s_dat_i};
        rsp1 = '{ack: (state_q == OWN1) & bus.s_ack_i,
                 err: (state_q == OWN1) & expire, dat: bus.s_dat_i};
    end

    assign bus.m0_ack_o   = rsp0.ack;
    assign bus.m0_err_o   = rsp0.err;
    assign bus.m0_dat_o   = rsp0.dat;
    assign bus.m1_ack_o   = rsp1.ack;
    assign bus.m1_err_o   = rsp1.err;
    assign bus.m1_dat_o   = rsp1.dat;
    assign timeout_irq_o  = expire;

endmodule

// File: tb/tb_soc_wb_arbiter.sv
// Bench for soc_wb_arbiter: two instances (TIMEOUT=8 and TIMEOUT=0) share one
// stimulus and are compared every cycle against an ownership-level model.
module tb_soc_wb_arbiter;
    import soc_wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  m_cyc, m_stb, m_we;
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        s_ack;
    logic [31:0] s_dat;
    logic        irq8, irq0;

    soc_wb_arbiter_if bus8 ();
    soc_wb_arbiter_if bus0 ();

    assign bus8.m0_cyc_i = m_cyc[0];  assign bus0.m0_cyc_i = m_cyc[0];
    assign bus8.m0_stb_i = m_stb[0];  assign bus0.m0_stb_i = m_stb[0];
    assign bus8.m0_we_i  = m_we[0];   assign bus0.m0_we_i  = m_we[0];
    assign bus8.m0_sel_i = m_sel[0];  assign bus0.m0_sel_i = m_sel[0];
    assign bus8.m0_adr_i = m_adr[0];  assign bus0.m0_adr_i = m_adr[0];
    assign bus8.m0_dat_i = m_dat[0];  assign bus0.m0_dat_i = m_dat[0];
    assign bus8.m1_cyc_i = m_cyc[1];  assign bus0.m1_cyc_i = m_cyc[1];
    assign bus8.m1_stb_i = m_stb[1];  assign bus0.m1_stb_i = m_stb[1];
    assign bus8.m1_we_i  = m_we[1];   assign bus0.m1_we_i  = m_we[1];
    assign bus8.m1_sel_i = m_sel[1];  assign bus0.m1_sel_i = m_sel[1];
    assign bus8.m1_adr_i = m_adr[1];  assign bus0.m1_adr_i = m_adr[1];
    assign bus8.m1_dat_i = m_dat[1];  assign bus0.m1_dat_i = m_dat[1];
    assign bus8.s_ack_i  = s_ack;     assign bus0.s_ack_i  = s_ack;
    assign bus8.s_dat_i  = s_dat;     assign bus0.s_dat_i  = s_dat;

    soc_wb_arbiter #(.TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus8), .timeout_irq_o(irq8)
    );
    soc_wb_arbiter #(.TIMEOUT(0)) dut_nowd (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0), .timeout_irq_o(irq0)
    );

    typedef struct packed {
        logic        s_cyc, s_stb, s_we;
        logic [3:0]  s_sel;
        logic [31:0] s_adr, s_dat;
        logic        ack0, err0, ack1, err1, irq;
        logic [31:0] dat0, dat1;
    } obs_t;

    obs_t obs8, obs0;
    assign obs8 = '{s_cyc: bus8.s_cyc_o, s_stb: bus8.s_stb_o, s_we: bus8.s_we_o,
                    s_sel: bus8.s_sel_o, s_adr: bus8.s_adr_o, s_dat: bus8.s_dat_o,
                    ack0: bus8.m0_ack_o, err0: bus8.m0_err_o, ack1: bus8.m1_ack_o,
                    err1: bus8.m1_err_o, irq: irq8, dat0: bus8.m0_dat_o, dat1: bus8.m1_dat_o};
    assign obs0 = '{s_cyc: bus0.s_cyc_o, s_stb: bus0.s_stb_o, s_we: bus0.s_we_o,
                    s_sel: bus0.s_sel_o, s_adr: bus0.s_adr_o, s_dat: bus0.s_dat_o,
                    ack0: bus0.m0_ack_o, err0: bus0.m0_err_o, ack1: bus0.m1_ack_o,
                    err1: bus0.m1_err_o, irq: irq0, dat0: bus0.m0_dat_o, dat1: bus0.m1_dat_o};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who owns the bus, who is preferred next, and how many
    // consecutive cycles the owner's strobe has gone unanswered.
    int m_own = -1;
    int m_ptr = 0;
    int m_w8  = 0;
    int m_w0  = 0;

    function automatic obs_t model_out(input int t, input int w);
        obs_t o = '0;
        logic expire;
        o.dat0 = s_dat;
        o.dat1 = s_dat;
        if (m_own >= 0) begin
            expire  = (t > 0) && m_stb[m_own] && !s_ack && (w == t);
            o.s_cyc = m_cyc[m_own];
            o.s_stb = m_stb[m_own] & ~expire;
            o.s_we  = m_we[m_own];
            o.s_sel = m_sel[m_own];
            o.s_adr = m_adr[m_own];
            o.s_dat = m_dat[m_own];
            o.irq   = expire;
            if (m_own == 0) begin o.ack0 = s_ack; o.err0 = expire; end
            else            begin o.ack1 = s_ack; o.err1 = expire; end
        end
        return o;
    endfunction

    function automatic int next_wait(input int t, input int w);
        bit stalled = (m_own >= 0) && m_stb[m_own] && !s_ack;
        bit expired = (t > 0) && stalled && (w == t);
        return (stalled && !expired) ? w + 1 : 0;
    endfunction

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_w8 = 0; m_w0 = 0;
    endtask

    task automatic model_step();
        bit r0, r1;
        m_w8 = next_wait(8, m_w8);
        m_w0 = next_wait(0, m_w0);
        r0 = m_cyc[0] && m_stb[0];
        r1 = m_cyc[1] && m_stb[1];
        if (m_own < 0) begin
            if (r0 && r1)  m_own = m_ptr;
            else if (r0)   m_own = 0;
            else if (r1)   m_own = 1;
        end else if (!m_cyc[m_own]) begin
            m_ptr = 1 - m_own;
            m_own = -1;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp_obs("model_t8", obs8, model_out(8, m_w8));
        cmp_obs("model_t0", obs0, model_out(0, m_w0));
    endtask

    // Cycle phases: inputs driven at posedge+1, outputs sampled at negedge.
    task automatic to_mid();
        #4;
    endtask

    task automatic end_cycle();
        #1;
        check_all();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic tick();
        to_mid();
        end_cycle();
    endtask

    task automatic rand_inputs(input bit slow_slave);
        for (int k = 0; k < 2; k++) begin
            if (!m_cyc[k]) begin
                if ($urandom_range(3) == 0) begin
                    m_cyc[k] = 1'b1;
                    m_stb[k] = 1'b1;
                    m_we[k]  = 1'($urandom_range(1));
                    m_sel[k] = 4'($urandom);
                    m_adr[k] = $urandom;
                    m_dat[k] = $urandom;
                end else begin
                    m_stb[k] = 1'b0;
                end
            end else if ($urandom_range(slow_slave ? 24 : 5) == 0) begin
                m_cyc[k] = 1'b0;
                m_stb[k] = 1'b0;
            end else begin
                m_stb[k] = ($urandom_range(3) != 0);
            end
        end
        s_ack = slow_slave ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0);
        s_dat = $urandom;
    endtask

    // Contention and bus-lock table: in = {m0 cyc,stb, m1 cyc,stb, s_ack},
    // ex = {s_cyc, s_stb, m0_ack, m1_ack}, src = whose address is on s_adr.
    typedef struct packed {
        bit [4:0] in;
        bit [3:0] ex;
        bit [1:0] src;
    } vec_t;

    vec_t tbl [21];
    logic [31:0] src_adr [3];

    initial begin
        logic [31:0] exp_adr;
        bit          e;

        m_cyc = '0; m_stb = '0; m_we = '0;
        m_sel[0] = 4'hF; m_sel[1] = 4'hF;
        m_adr[0] = 32'h1000_0000; m_adr[1] = 32'h2000_0000;
        m_dat[0] = 32'h0000_00A0; m_dat[1] = 32'h0000_00B1;
        s_ack = 1'b0; s_dat = 32'h5A5A_0000;
        src_adr[0] = 32'h0; src_adr[1] = 32'h1000_0000; src_adr[2] = 32'h2000_0000;

        tbl[0]  = {5'b11110, 4'b0000, 2'd0};
        tbl[1]  = {5'b11111, 4'b1110, 2'd1};
        tbl[2]  = {5'b00110, 4'b0000, 2'd1};
        tbl[3]  = {5'b11111, 4'b0000, 2'd0};
        tbl[4]  = {5'b11111, 4'b1101, 2'd2};
        tbl[5]  = {5'b11000, 4'b0000, 2'd2};
        tbl[6]  = {5'b11111, 4'b0000, 2'd0};
        tbl[7]  = {5'b11111, 4'b1110, 2'd1};
        tbl[8]  = {5'b00110, 4'b0000, 2'd1};
        tbl[9]  = {5'b11110, 4'b0000, 2'd0};
        tbl[10] = {5'b11111, 4'b1101, 2'd2};
        tbl[11] = {5'b11100, 4'b1000, 2'd2};
        tbl[12] = {5'b11111, 4'b1101, 2'd2};
        tbl[13] = {5'b11111, 4'b1101, 2'd2};
        tbl[14] = {5'b11100, 4'b1000, 2'd2};
        tbl[15] = {5'b11111, 4'b1101, 2'd2};
        tbl[16] = {5'b11000, 4'b0000, 2'd2};
        tbl[17] = {5'b11000, 4'b0000, 2'd0};
        tbl[18] = {5'b11000, 4'b1100, 2'd1};
        tbl[19] = {5'b00000, 4'b0000, 2'd1};
        tbl[20] = {5'b00000, 4'b0000, 2'd0};

        model_reset();
        @(posedge clk); #1;
        to_mid();
        cmp("reset_s_cyc", 32'(bus8.s_cyc_o), 32'd0);
        cmp("reset_irq", 32'(irq8), 32'd0);
        end_cycle();
        rst_n = 1'b1;

        // Round-robin contention followed by a 4-strobe lock from m1.
        for (int i = 0; i < 21; i++) begin
            {m_cyc[0], m_stb[0], m_cyc[1], m_stb[1], s_ack} = tbl[i].in;
            to_mid();
            cmp($sformatf("tbl%0d_ctl", i),
                32'({bus8.s_cyc_o, bus8.s_stb_o, bus8.m0_ack_o, bus8.m1_ack_o}), 32'(tbl[i].ex));
            exp_adr = src_adr[tbl[i].src];
            cmp($sformatf("tbl%0d_adr", i), bus8.s_adr_o, exp_adr);
            end_cycle();
        end

        // Reset in the middle of an m1 transfer; pointer is 1 at this point.
        m_adr[0] = 32'hA000_0000; m_adr[1] = 32'hB000_0000;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick(); tick(); tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b1;
        #2;
        cmp("pre_reset_s_cyc", 32'(bus8.s_cyc_o), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_s_cyc", 32'(bus8.s_cyc_o), 32'd0);
        cmp("rst_m1_ack", 32'(bus8.m1_ack_o), 32'd0);
        cmp("rst_irq", 32'(irq8), 32'd0);
        end_cycle();
        rst_n = 1'b1;
        s_ack = 1'b0;
        tick();
        to_mid();
        cmp("post_rst_grant_adr", bus8.s_adr_o, 32'hA000_0000);
        cmp("post_rst_grant_cyc", 32'(bus8.s_cyc_o), 32'd1);
        end_cycle();
        m_cyc = '0; m_stb = '0;
        tick(); tick();

        // Single write from m0, slave acks two cycles after the grant.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hF;
        m_adr[0] = 32'h3000_0004; m_dat[0] = 32'hDEAD_BEEF;
        to_mid();
        cmp("wr_n_cyc", 32'(bus8.s_cyc_o), 32'd0);
        end_cycle();
        to_mid();
        cmp("wr_adr", bus8.s_adr_o, 32'h3000_0004);
        cmp("wr_dat", bus8.s_dat_o, 32'hDEAD_BEEF);
        cmp("wr_sel_we", 32'({bus8.s_sel_o, bus8.s_we_o}), 32'h1F);
        cmp("wr_early_ack", 32'(bus8.m0_ack_o), 32'd0);
        end_cycle();
        tick();
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        to_mid();
        cmp("wr_m0_ack", 32'(bus8.m0_ack_o), 32'd1);
        cmp("wr_m1_noack", 32'(bus8.m1_ack_o), 32'd0);
        cmp("wr_m1_dat", bus8.m1_dat_o, 32'h1234_5678);
        end_cycle();
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
        tick(); tick();

        // Watchdog: slave silent, expiry every 9 cycles; ack wins on the third.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        for (int i = 0; i < 27; i++) begin
            s_ack = (i == 26);
            e = (i == 8) || (i == 17);
            to_mid();
            cmp($sformatf("wd%0d_err", i), 32'({bus8.m0_err_o, irq8, bus8.s_stb_o}),
                32'({e, e, !e}));
            cmp($sformatf("wd%0d_nowd", i), 32'({bus0.m0_err_o, irq0, bus0.s_stb_o}), 32'b001);
            if (i == 26)
                cmp("race_ack_err", 32'({bus8.m0_ack_o, bus8.m0_err_o, irq8}), 32'b100);
            end_cycle();
        end
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        tick(); tick();

        // Random traffic, alternating responsive and sluggish slave phases.
        for (int c = 0; c < 4000; c++) begin
            rand_inputs(((c / 250) % 2) == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
